// File: rtl/tag_rx_ctrl.sv
// Capture sequencer for the tag receive chain: sweep reset, sync wait, then
// gates a configured number of fixed-length packets onto the host AXI-Stream.
module tag_rx_ctrl #(
    parameter int DATA_WIDTH    = 16,
    parameter int CNT_WIDTH     = 16,
    parameter int TIMEOUT_WIDTH = 32,
    parameter int SRST_CYCLES   = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CNT_WIDTH-1:0]     cfg_pkt_len,
    input  logic [CNT_WIDTH-1:0]     cfg_npkt,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
    output logic                     rx_srst,
    input  logic                     sync_ready,
    output logic                     phase_tvalid,
    output logic                     phase_tlast,
    input  logic                     phase_tready,
    input  logic [2*DATA_WIDTH-1:0]  s_tdata,
    input  logic                     s_tvalid,
    input  logic                     s_tlast,
    output logic                     s_tready,
    output logic [2*DATA_WIDTH-1:0]  m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    input  logic                     m_tready,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err,
    output logic                     cfg_err,
    output logic                     sync_lost,
    output logic [CNT_WIDTH-1:0]     pkt_count,
    output logic [2:0]               state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        WAIT_SYNC = 3'd2,
        CAPTURE   = 3'd3,
        DRAIN     = 3'd4
    } state_t;

    localparam int SRST_W = (SRST_CYCLES > 1) ? $clog2(SRST_CYCLES) : 1;

    state_t                   cur;
    logic [CNT_WIDTH-1:0]     pkt_len_q;
    logic [CNT_WIDTH-1:0]     npkt_q;
    logic [TIMEOUT_WIDTH-1:0] timeout_q;
    logic [TIMEOUT_WIDTH-1:0] timer;
    logic [CNT_WIDTH-1:0]     sample_cnt;
    logic [SRST_W-1:0]        srst_cnt;

    logic pass;
    logic beat;
    logic pkt_end;
    logic cap_end;
    logic unused_inputs;

    assign pass    = (cur == CAPTURE) || (cur == DRAIN);
    assign beat    = pass && s_tvalid && m_tready;
    assign pkt_end = (sample_cnt == pkt_len_q - CNT_WIDTH'(1));
    assign cap_end = pkt_end && (pkt_count == npkt_q - CNT_WIDTH'(1));

    // Streaming path is purely combinational so capture adds no latency.
    assign m_tdata      = s_tdata;
    assign m_tvalid     = pass && s_tvalid;
    assign m_tlast      = ((cur == CAPTURE) && pkt_end) || (cur == DRAIN);
    assign s_tready     = reset_n && (pass ? m_tready : 1'b1);
    assign phase_tvalid = (cur == WAIT_SYNC) || (cur == CAPTURE);
    assign phase_tlast  = (cur == CAPTURE) && beat && cap_end;
    assign rx_srst      = (cur == ARM);
    assign busy         = (cur != IDLE);
    assign state        = cur;

    // Upstream framing and DDS backpressure are deliberately not used.
    assign unused_inputs = &{1'b0, phase_tready, s_tlast};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur         <= IDLE;
            pkt_len_q   <= '0;
            npkt_q      <= '0;
            timeout_q   <= '0;
            timer       <= '0;
            sample_cnt  <= '0;
            srst_cnt    <= '0;
            pkt_count   <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            cfg_err     <= 1'b0;
            sync_lost   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (cur)
                IDLE: begin
                    if (start) begin
                        if (cfg_pkt_len == '0 || cfg_npkt == '0) begin
                            cfg_err <= 1'b1;
                        end else begin
                            pkt_len_q   <= cfg_pkt_len;
                            npkt_q      <= cfg_npkt;
                            timeout_q   <= cfg_timeout;
                            pkt_count   <= '0;
                            srst_cnt    <= '0;
                            timeout_err <= 1'b0;
                            cfg_err     <= 1'b0;
                            sync_lost   <= 1'b0;
                            cur         <= ARM;
                        end
                    end
                end
                ARM: begin
                    if (abort) begin
                        cur <= IDLE;
                    end else if (srst_cnt == SRST_W'(SRST_CYCLES - 1)) begin
                        timer <= '0;
                        cur   <= WAIT_SYNC;
                    end else begin
                        srst_cnt <= srst_cnt + SRST_W'(1);
                    end
                end
                WAIT_SYNC: begin
                    timer <= timer + TIMEOUT_WIDTH'(1);
                    if (abort) begin
                        cur <= IDLE;
                    end else if (sync_ready) begin
                        sample_cnt <= '0;
                        pkt_count  <= '0;
                        cur        <= CAPTURE;
                    end else if (timeout_q != '0 &&
                                 timer == timeout_q - TIMEOUT_WIDTH'(1)) begin
                        timeout_err <= 1'b1;
                        cur         <= IDLE;
                    end
                end
                CAPTURE: begin
                    if (!sync_ready) sync_lost <= 1'b1;
                    if (beat) begin
                        if (pkt_end) begin
                            sample_cnt <= '0;
                            pkt_count  <= pkt_count + CNT_WIDTH'(1);
                        end else begin
                            sample_cnt <= sample_cnt + CNT_WIDTH'(1);
                        end
                    end
                    // Completion beats an abort in the same cycle; an abort on a
                    // tlast beat needs no drain beat.
                    if (beat && cap_end) begin
                        done <= 1'b1;
                        cur  <= IDLE;
                    end else if (abort) begin
                        cur <= (beat && pkt_end) ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (beat) cur <= IDLE;
                end
                default: cur <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tag_rx_ctrl.sv
// Directed bench for tag_rx_ctrl: a table of capture scenarios with hand-computed
// results, plus hand-written config-error and mid-capture reset sequences.
module tb_tag_rx_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, abort;
    logic [15:0] cfg_pkt_len, cfg_npkt;
    logic [31:0] cfg_timeout;
    logic        rx_srst, sync_ready, phase_tvalid, phase_tlast, phase_tready;
    logic [31:0] s_tdata, m_tdata;
    logic        s_tvalid, s_tlast, s_tready, m_tvalid, m_tlast, m_tready;
    logic        busy, done, timeout_err, cfg_err, sync_lost;
    logic [15:0] pkt_count;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    tag_rx_ctrl #(
        .DATA_WIDTH(16), .CNT_WIDTH(16), .TIMEOUT_WIDTH(32), .SRST_CYCLES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cfg_pkt_len(cfg_pkt_len), .cfg_npkt(cfg_npkt), .cfg_timeout(cfg_timeout),
        .rx_srst(rx_srst), .sync_ready(sync_ready),
        .phase_tvalid(phase_tvalid), .phase_tlast(phase_tlast), .phase_tready(phase_tready),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .busy(busy), .done(done), .timeout_err(timeout_err), .cfg_err(cfg_err),
        .sync_lost(sync_lost), .pkt_count(pkt_count), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pkt_len; int npkt; int timeout;
        int sync_delay;   // WAIT_SYNC cycles with sync low; -1 = never
        int mode;         // 0: valid/ready always 1; 1: ready 1010.., valid random
        int abort_beat;   // abort asserted during this beat; -1 = none
        int restart_beat; // start + new cfg during this beat; -1 = none
        int drop_beat;    // sync_ready low during this beat; -1 = none
        int exp_beats; int exp_tlasts; int exp_pkt; int exp_done;
        int exp_terr; int exp_slost; int exp_wait;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  beats, tl, srst, waitc, dn, ptl, bad_idle, cyc;
        bit  synced, aborted, restarted, fin, exp_last;
        beats = 0; tl = 0; srst = 0; waitc = 0; dn = 0; ptl = 0; bad_idle = 0; cyc = 0;
        synced = 0; aborted = 0; restarted = 0; fin = 0;
        @(negedge clk);
        cfg_pkt_len = 16'(v.pkt_len); cfg_npkt = 16'(v.npkt); cfg_timeout = 32'(v.timeout);
        start = 1'b1; abort = 1'b0; sync_ready = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
        @(negedge clk);
        while (!fin && cyc < 2000) begin
            start = 1'b0;
            abort = 1'b0;
            if (v.abort_beat >= 0 && !aborted && beats == v.abort_beat - 1) begin
                abort = 1'b1; aborted = 1;
            end
            if (v.restart_beat >= 0 && !restarted && beats == v.restart_beat - 1) begin
                start = 1'b1; restarted = 1;
                cfg_pkt_len = 16'd2; cfg_npkt = 16'd1; cfg_timeout = 32'd3;
            end
            if (state == 3'd2 && v.sync_delay >= 0 && waitc >= v.sync_delay) synced = 1;
            sync_ready = synced && !(v.drop_beat >= 0 && beats == v.drop_beat - 1 && state == 3'd3);
            if (v.mode == 0) begin
                s_tvalid = 1'b1; m_tready = 1'b1;
            end else begin
                s_tvalid = 1'($urandom_range(0, 1)); m_tready = (cyc % 2 == 0);
            end
            s_tdata = $urandom;
            #1;
            if (rx_srst) srst++;
            if (state == 3'd2) waitc++;
            if (done) dn++;
            if (phase_tlast) ptl++;
            if (state <= 3'd2 && (m_tvalid || !s_tready)) bad_idle++;
            if (m_tvalid && m_tready) begin
                beats++;
                exp_last = (beats % v.pkt_len == 0) ||
                           (v.abort_beat >= 0 && beats == v.abort_beat + 1);
                if (exp_last) tl++;
                check($sformatf("v%0d_beat%0d_tlast", idx, beats), m_tlast, exp_last);
                check($sformatf("v%0d_beat%0d_tdata", idx, beats), m_tdata, s_tdata);
            end
            if (state == 3'd0) fin = 1;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0; sync_ready = 1'b0;
        #1;
        check($sformatf("v%0d_finished", idx), fin, 1);
        check($sformatf("v%0d_srst_cycles", idx), srst, 2);
        check($sformatf("v%0d_wait_cycles", idx), waitc, v.exp_wait);
        check($sformatf("v%0d_beats", idx), beats, v.exp_beats);
        check($sformatf("v%0d_tlasts", idx), tl, v.exp_tlasts);
        check($sformatf("v%0d_pkt_count", idx), pkt_count, v.exp_pkt);
        check($sformatf("v%0d_done_pulses", idx), dn, v.exp_done);
        check($sformatf("v%0d_phase_tlast", idx), ptl, v.exp_done);
        check($sformatf("v%0d_timeout_err", idx), timeout_err, v.exp_terr);
        check($sformatf("v%0d_sync_lost", idx), sync_lost, v.exp_slost);
        check($sformatf("v%0d_cfg_err", idx), cfg_err, 0);
        check($sformatf("v%0d_quiet_outside_capture", idx), bad_idle, 0);
        check($sformatf("v%0d_done_after", idx), done, 0);
        check($sformatf("v%0d_busy_after", idx), busy, 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_flags"},
              {rx_srst, phase_tvalid, phase_tlast, s_tready, m_tvalid, m_tlast,
               busy, done, timeout_err, cfg_err, sync_lost}, 0);
        check({name, "_pkt_count"}, pkt_count, 0);
        check({name, "_state"}, state, 0);
    endtask

    initial begin
        //          len npkt  tmo  syn md  abt rst drp | beats tl pkt dn te sl wait
        vecs[0]  = '{4, 3,    0,   10, 0, -1, -1, -1,   12,  3, 3,  1, 0, 0, 11};
        vecs[1]  = '{4, 3,    0,   10, 1, -1, -1, -1,   12,  3, 3,  1, 0, 0, 11};
        vecs[2]  = '{4, 3,    20,  -1, 0, -1, -1, -1,   0,   0, 0,  0, 1, 0, 20};
        vecs[3]  = '{8, 4,    0,   3,  0, 10, -1, -1,   11,  2, 1,  0, 0, 0, 4};
        vecs[4]  = '{1, 5,    0,   0,  0, -1, -1, -1,   5,   5, 5,  1, 0, 0, 1};
        vecs[5]  = '{3, 2,    50,  5,  0, -1, -1, -1,   6,   2, 2,  1, 0, 0, 6};
        vecs[6]  = '{2, 1,    5,   4,  0, -1, -1, -1,   2,   1, 1,  1, 0, 0, 5};
        vecs[7]  = '{2, 1,    5,   5,  0, -1, -1, -1,   0,   0, 0,  0, 1, 0, 5};
        vecs[8]  = '{4, 2,    0,   2,  0, -1, 4,  -1,   8,   2, 2,  1, 0, 0, 3};
        vecs[9]  = '{2, 2,    0,   1,  0, -1, -1, 3,    4,   2, 2,  1, 0, 1, 2};
        vecs[10] = '{3, 2,    0,   0,  1, -1, -1, -1,   6,   2, 2,  1, 0, 0, 1};

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; sync_ready = 1'b0;
        cfg_pkt_len = '0; cfg_npkt = '0; cfg_timeout = '0;
        phase_tready = 1'b1; s_tdata = '0; s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b1;
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("idle_s_tready", s_tready, 1);
        check("idle_state", state, 0);

        // Zero-length or zero-count configs are rejected and leave the FSM idle.
        @(negedge clk);
        cfg_pkt_len = 16'd4; cfg_npkt = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("cfg_err_npkt0", cfg_err, 1);
        check("cfg_err_npkt0_state", state, 0);
        @(negedge clk);
        cfg_pkt_len = 16'd0; cfg_npkt = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("cfg_err_len0_state", state, 0);
        check("cfg_err_len0_busy", busy, 0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Asynchronous reset while beat 5 is on the bus.
        begin
            int beats, cyc;
            beats = 0; cyc = 0;
            @(negedge clk);
            cfg_pkt_len = 16'd4; cfg_npkt = 16'd3; cfg_timeout = '0; start = 1'b1;
            s_tvalid = 1'b1; m_tready = 1'b1; sync_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (beats < 4 && cyc < 200) begin
                #1;
                if (m_tvalid && m_tready) beats++;
                cyc++;
                @(negedge clk);
            end
            #1;
            check("rst_mid_reached_beat5", beats == 4 && m_tvalid, 1);
            reset_n = 1'b0;
            #1;
            check_all_zero("rst_mid");
            @(negedge clk);
            @(negedge clk);
            sync_ready = 1'b0;
            reset_n = 1'b1;
        end
        run_vec(vecs[0], 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tag_rx_ctrl.md
Name: tag_rx_ctrl

Overview:
Capture sequencer for the tag receive chain. On a start command it resets the downconverter's phase sweep and streams phase-valid to the DDS. It waits for the localisation sync indication, then gates a configured number of fixed-length packets from the baseband stream to the host-side AXI-Stream. Packet framing (tlast) is regenerated locally; upstream tlast is ignored.

Parameters:
DATA_WIDTH, 16, width of each I/Q component
CNT_WIDTH, 16, width of packet-length and packet-count configuration and counters
TIMEOUT_WIDTH, 32, width of the sync-wait timeout counter
SRST_CYCLES, 2, length of the rx_srst pulse in clocks (>=1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle command, accepted only in IDLE
abort  in  1  one-cycle command to terminate the current operation
cfg_pkt_len  in  CNT_WIDTH  samples per packet, latched on start
cfg_npkt  in  CNT_WIDTH  packets per capture, latched on start
cfg_timeout  in  TIMEOUT_WIDTH  sync-wait limit in clocks; 0 = wait forever
rx_srst  out  1  synchronous sweep reset to the receive datapath
sync_ready  in  1  localisation sync indication from the datapath
phase_tvalid  out  1  phase stream valid to the DDS
phase_tlast  out  1  phase stream last
phase_tready  in  1  phase stream ready (monitored only)
s_tdata  in  2*DATA_WIDTH  {I,Q} baseband input
s_tvalid  in  1  input valid
s_tlast  in  1  input last (ignored)
s_tready  out  1  input ready
m_tdata  out  2*DATA_WIDTH  {I,Q} output
m_tvalid  out  1  output valid
m_tlast  out  1  output last
m_tready  in  1  output ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on normal completion
timeout_err  out  1  sticky; cleared on the next accepted start
cfg_err  out  1  sticky; cleared on the next accepted start
sync_lost  out  1  sticky; sync_ready fell during CAPTURE; cleared on the next accepted start
pkt_count  out  CNT_WIDTH  completed packets in the current or last capture
state  out  3  current state: IDLE=0, ARM=1, WAIT_SYNC=2, CAPTURE=3, DRAIN=4

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0 except m_tdata, which is a don't-care passthrough. All counters and flags 0.
- IDLE:
  - s_tready=1; input samples are discarded.
  - start with cfg_pkt_len==0 or cfg_npkt==0: stay IDLE, cfg_err=1.
  - Otherwise latch config, clear flags and pkt_count, go to ARM.
  - abort is ignored.
- ARM:
  - rx_srst=1 for exactly SRST_CYCLES cycles, then WAIT_SYNC.
  - s_tready=1 (flush).
  - abort → IDLE next cycle; rx_srst drops immediately.
- WAIT_SYNC:
  - phase_tvalid=1, s_tready=1 (flush); timer increments each clock.
  - sync_ready=1 → CAPTURE next cycle; sample and packet counters start at 0.
  - cfg_timeout!=0 and timer==cfg_timeout-1 with no sync → IDLE, timeout_err=1.
  - If sync and timeout coincide, sync wins.
  - abort → IDLE.
- CAPTURE:
  - phase_tvalid=1.
  - Combinational passthrough: m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready. Zero added latency.
  - A beat is one cycle with s_tvalid and m_tready both high; the sample counter increments per beat.
  - m_tlast=1 when sample counter==cfg_pkt_len-1. On that beat the sample counter wraps to 0 and pkt_count increments.
  - Last beat of packet cfg_npkt: phase_tlast=1 in the same cycle, done pulses the next cycle, state → IDLE.
  - sync_ready low during CAPTURE sets sync_lost; capture continues.
  - abort → DRAIN. Already-started packets are never left without a tlast.
- DRAIN:
  - Passthrough continues. m_tlast is forced high on the next beat; after that beat → IDLE, with no done pulse.
  - If abort arrives on a beat that already carries m_tlast, go directly to IDLE.
- start while busy is ignored. cfg_* changes after start have no effect.
- pkt_count holds its value in IDLE until the next accepted start.
- Counters use CNT_WIDTH unsigned arithmetic. cfg_pkt_len=1 gives tlast on every beat. Max values 2^CNT_WIDTH-1 are legal.
- phase_tready does not stall the FSM.
- Async reset mid-capture: returns to IDLE immediately and clears all outputs (m_tvalid=0).

Test Plan:
1. pkt_len=4, npkt=3, timeout=0, sync_ready rises 10 cycles after start, s_tvalid and m_tready constant 1 → rx_srst high 2 cycles; 12 output beats with tlast on beats 4/8/12; phase_tlast on beat 12; done one cycle later; pkt_count=3.
2. Same config with m_tready toggling 1010… and s_tvalid random → exactly 12 beats, tlast positions unchanged, no beats lost or duplicated.
3. timeout=20, sync_ready held 0 → IDLE after 20 WAIT_SYNC cycles, timeout_err=1, no m_tvalid. A following good start clears timeout_err.
4. pkt_len=8, npkt=4, abort after beat 10 → DRAIN; next beat (11) has tlast; IDLE; done never asserts; pkt_count=1.
5. start with npkt=0 → cfg_err=1, state stays 0. start during CAPTURE → ignored; latched config unchanged.
6. reset_n asserted during CAPTURE beat 5 → all outputs 0 asynchronously. After release, a normal capture (scenario 1) completes correctly.
